// File: rtl/controller_pkg.sv
// Shared types and constants for the gamepad controller and its UART helpers.
package controller_pkg;

  // Main read sequencer states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_READ,
    ST_DONE
  } ctrl_state_e;

  // Command receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] CMD_POLL    = 8'h70;
  localparam int         NUM_BUTTONS = 8;
  localparam int         FRAME_BITS  = 10;  // start + 8 data + stop

  // Cycles per UART bit, rounded to nearest
  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF input synchronizer, falling-edge start detect, mid-bit sampling.
// valid pulses for one cycle, the cycle after a good stop bit is sampled; a low stop
// bit discards the byte. Re-arming needs a fresh falling edge, so a framing error
// cannot retrigger on a line that is still low.
module uart_rx
  import controller_pkg::*;
#(
  parameter int BAUD_DIV = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       valid,
  output logic [7:0] dout
);

  localparam int            DW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(BAUD_DIV - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'((BAUD_DIV / 2 > 0) ? (BAUD_DIV / 2 - 1) : 0);

  logic          meta_q, sync_q, prev_q;
  rx_state_e     st_q, st_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_q, valid_d;
  logic [7:0]    dout_q, dout_d;

  // Synchronize the asynchronous line and keep one cycle of history for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rxd;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Receive sequencer: half a bit to mid-start, then one bit period per sample
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    dout_d  = dout_q;
    case (st_q)
      RX_IDLE: begin
        if (prev_q && !sync_q) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          sh_d  = {sync_q, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            st_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          st_d  = RX_IDLE;
          if (sync_q) begin
            valid_d = 1'b1;
            dout_d  = sh_q;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

  assign valid = valid_q;
  assign dout  = dout_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit, BAUD_DIV cycles each.
// A start request is accepted only while idle; busy stays high through the stop bit.
module uart_tx
  import controller_pkg::*;
#(
  parameter int BAUD_DIV = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       txd
);

  localparam int            DW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DIV - 1);
  localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          busy_q, busy_d;
  logic          txd_q, txd_d;

  // Load a frame when idle, otherwise shift one bit every BAUD_DIV cycles
  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    txd_d   = txd_q;
    if (!busy_q) begin
      if (start) begin
        frame_d = {1'b1, din, 1'b0};
        busy_d  = 1'b1;
        div_d   = '0;
        bit_d   = '0;
        txd_d   = 1'b0;
      end
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (bit_q == BIT_LAST) begin
        busy_d = 1'b0;
        txd_d  = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        frame_d = {1'b1, frame_q[9:1]};
        txd_d   = frame_q[1];
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // Serializer state registers; line idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      bit_q   <= '0;
      frame_q <= '1;
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      txd_q   <= txd_d;
    end
  end

  assign busy = busy_q;
  assign txd  = txd_q;

endmodule

// File: rtl/gamepad_controller.sv
// NES-style pad reader: periodic latch pulse, 8 shift pulses, publishes the byte
// with a ready strobe and reports it over UART.
// Optional macro CONTROLLER_UART_CMD_EN adds a UART receiver; byte 8'h70 requests a poll.
// Segment scheme of one read: segment 0 = poll pulse, odd segments = gaps,
// even segments 2..16 = sample pulses, each PULSE_CYC cycles; DONE follows segment 16.
module gamepad_controller
  import controller_pkg::*;
#(
  parameter int CLK_HZ      = 10_000_000,
  parameter int BAUD        = 115_200,
  parameter int PULSE_CYC   = 60,
  parameter int POLL_PERIOD = 166_667
) (
  input  logic       SYSCLK,
  input  logic       SYSRESET,
  input  logic       data,
  input  logic       UART_0_RXD,
  output logic       ready,
  output logic       poll,
  output logic       sample,
  output logic [7:0] buttonData,
  output logic       UART_0_TXD
);

  localparam int            BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
  localparam int            PW       = $clog2(PULSE_CYC);
  localparam int            TW       = $clog2(POLL_PERIOD);
  localparam logic [PW-1:0] P_LAST   = PW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(POLL_PERIOD - 1);
  localparam logic [4:0]    SEG_LAST = 5'(2 * NUM_BUTTONS);

  logic          data_meta_q, data_sync_q;
  logic [TW-1:0] timer_q, timer_d;
  logic          timer_wrap;
  logic          cmd_req;
  logic          poll_req;

  ctrl_state_e   state_q, state_d;
  logic [4:0]    seg_q, seg_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [7:0]    cap_q, cap_d;
  logic [7:0]    btn_q, btn_d;
  logic          poll_q, poll_d;
  logic          sample_q, sample_d;
  logic          ready_q, ready_d;

  logic          tx_busy;
  logic          tx_start;

`ifdef CONTROLLER_UART_CMD_EN
  logic       rx_valid;
  logic [7:0] rx_byte;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk   (SYSCLK),
    .rst   (SYSRESET),
    .rxd   (UART_0_RXD),
    .valid (rx_valid),
    .dout  (rx_byte)
  );

  assign cmd_req = rx_valid && (rx_byte == CMD_POLL);
`else
  logic unused_rxd;
  assign unused_rxd = UART_0_RXD;
  assign cmd_req    = 1'b0;
`endif

  // Timer wrap and command merge into a single request; dropped unless IDLE
  assign timer_wrap = (timer_q == T_LAST);
  assign poll_req   = timer_wrap || cmd_req;

  // Two-flop synchronizer for the pad data line (idles high = nothing pressed)
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      data_meta_q <= data;
      data_sync_q <= data_meta_q;
    end
  end

  // Next-state, capture and output decode; outputs registered from next state
  always_comb begin
    timer_d = timer_wrap ? '0 : timer_q + TW'(1);
    state_d = state_q;
    seg_d   = seg_q;
    pcnt_d  = pcnt_q;
    cap_d   = cap_q;
    btn_d   = btn_q;
    case (state_q)
      ST_IDLE: begin
        if (poll_req) begin
          state_d = ST_LATCH;
          seg_d   = '0;
          pcnt_d  = '0;
        end
      end
      ST_LATCH, ST_READ: begin
        // Last cycle of a gap: capture bit (segment/2), inverting active-low data
        if (state_q == ST_READ && seg_q[0] && pcnt_q == P_LAST) begin
          cap_d[seg_q[3:1]] = ~data_sync_q;
        end
        if (pcnt_q == P_LAST) begin
          pcnt_d = '0;
          if (seg_q == SEG_LAST) begin
            state_d = ST_DONE;
          end else begin
            seg_d   = seg_q + 5'd1;
            state_d = ST_READ;
          end
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_DONE) begin
      btn_d = cap_d;
    end
    poll_d   = (state_d == ST_LATCH);
    sample_d = (state_d == ST_READ) && !seg_d[0];
    ready_d  = (state_d == ST_DONE);
  end

  // Sequencer, timer and output registers
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      timer_q  <= '0;
      state_q  <= ST_IDLE;
      seg_q    <= '0;
      pcnt_q   <= '0;
      cap_q    <= '0;
      btn_q    <= '0;
      poll_q   <= 1'b0;
      sample_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      state_q  <= state_d;
      seg_q    <= seg_d;
      pcnt_q   <= pcnt_d;
      cap_q    <= cap_d;
      btn_q    <= btn_d;
      poll_q   <= poll_d;
      sample_q <= sample_d;
      ready_q  <= ready_d;
    end
  end

  // Report the fresh byte during DONE; a busy transmitter means the report is lost
  assign tx_start = (state_q == ST_DONE) && !tx_busy;

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk   (SYSCLK),
    .rst   (SYSRESET),
    .start (tx_start),
    .din   (btn_q),
    .busy  (tx_busy),
    .txd   (UART_0_TXD)
  );

  assign poll       = poll_q;
  assign sample     = sample_q;
  assign ready      = ready_q;
  assign buttonData = btn_q;

endmodule

// File: tb/tb_gamepad_controller.sv
// Scoreboard bench for gamepad_controller (P=4, period 200, BAUD_DIV=10).
// A pad model pushes the expected byte at every poll; monitors pop and compare on
// ready and on each completed UART frame.
module tb_gamepad_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data = 1'b1;
  logic       rxd = 1'b1;
  logic       ready, poll, sample, txd;
  logic [7:0] btn;

  gamepad_controller #(
    .CLK_HZ      (10_000_000),
    .BAUD        (1_000_000),
    .PULSE_CYC   (4),
    .POLL_PERIOD (200)
  ) dut (
    .SYSCLK     (clk),
    .SYSRESET   (rst),
    .data       (data),
    .UART_0_RXD (rxd),
    .ready      (ready),
    .poll       (poll),
    .sample     (sample),
    .buttonData (btn),
    .UART_0_TXD (txd)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] pattern;
  logic [7:0] exp_btn_q[$];
  logic [7:0] exp_tx_q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %-22s got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %-22s 'h%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Pad model: latches pattern on poll, shifts on each sample rise; data active-low
  logic [7:0] pad_pat = 8'h00;
  int         pad_idx = 0;
  logic       pad_poll_p = 1'b0, pad_sample_p = 1'b0;
  always @(negedge clk) begin
    if (poll && !pad_poll_p) begin
      pad_pat = pattern;
      pad_idx = 0;
      data    = ~pattern[0];
      exp_btn_q.push_back(pattern);
      exp_tx_q.push_back(pattern);
    end
    if (sample && !pad_sample_p) begin
      pad_idx++;
      data = (pad_idx < 8) ? ~pad_pat[pad_idx] : 1'b1;
    end
    pad_poll_p   = poll;
    pad_sample_p = sample;
  end

  // Read-side monitor: pulse widths, period, latency and buttonData against scoreboard
  logic mpoll_p = 1'b0, msample_p = 1'b0, mready_p = 1'b0;
  int   poll_rise = 0, last_poll = -1, sample_rise = 0, ready_rise = 0, samples = 0;
  bit   period_chk = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      last_poll = -1;
      samples   = 0;
    end else begin
      if (poll && !mpoll_p) begin
        if (last_poll >= 0 && period_chk) check("poll_period", cyc - last_poll, 200);
        last_poll = cyc;
        poll_rise = cyc;
        samples   = 0;
      end
      if (!poll && mpoll_p) check("poll_width", cyc - poll_rise, 4);
      if (sample && !msample_p) begin
        samples++;
        sample_rise = cyc;
      end
      if (!sample && msample_p) check("sample_width", cyc - sample_rise, 4);
      if (ready && !mready_p) begin
        check("ready_latency", cyc - poll_rise, 68);
        check("sample_pulses", samples, 8);
        check("exp_btn_queued", int'(exp_btn_q.size() > 0), 1);
        if (exp_btn_q.size() > 0) check("buttonData", int'(btn), int'(exp_btn_q.pop_front()));
        ready_rise = cyc;
      end
      if (!ready && mready_p) check("ready_width", cyc - ready_rise, 1);
    end
    mpoll_p   = poll;
    msample_p = sample;
    mready_p  = ready;
  end

  // TX monitor: each bit sampled near both ends of its 10-cycle slot
  logic       mtx_p = 1'b1;
  bit         tx_act = 1'b0;
  int         tx_cnt = 0;
  logic [9:0] tx_a, tx_b, tx_exp;
  always @(negedge clk) begin
    if (rst) begin
      tx_act = 1'b0;
    end else if (!tx_act) begin
      if (!txd && mtx_p) begin
        tx_act = 1'b1;
        tx_cnt = 0;
        tx_a   = '0;
        tx_b   = '0;
      end
    end else begin
      tx_cnt++;
      if (tx_cnt % 10 == 1) tx_a[tx_cnt / 10] = txd;
      if (tx_cnt % 10 == 9) tx_b[tx_cnt / 10] = txd;
      if (tx_cnt == 99) begin
        tx_act = 1'b0;
        check("exp_tx_queued", int'(exp_tx_q.size() > 0), 1);
        if (exp_tx_q.size() > 0) begin
          tx_exp = {1'b1, exp_tx_q.pop_front(), 1'b0};
          check("tx_frame_early", int'(tx_a), int'(tx_exp));
          check("tx_frame_late", int'(tx_b), int'(tx_exp));
        end
      end
    end
    mtx_p = txd;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_poll"}, int'(poll), 0);
    check({tag, "_sample"}, int'(sample), 0);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_buttonData"}, int'(btn), 0);
    check({tag, "_txd"}, int'(txd), 1);
  endtask

  // Counts clocks from a release at negedge until poll is seen high
  task automatic wait_first_poll(input string name);
    int n = 0;
    bit seen = 1'b0;
    while (n < 400 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = poll;
    end
    check(name, n, 200);
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    bit seen = 1'b0;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      seen = ready;
    end
    check("ready_seen", int'(seen), 1);
  endtask

  task automatic wait_sample_rises(input int k);
    int  n = 0, rises = 0;
    logic p = sample;
    while (n < 200 && rises < k) begin
      @(negedge clk);
      n++;
      if (sample && !p) rises++;
      p = sample;
    end
    check("sample_rises_seen", rises, k);
  endtask

  task automatic pulse_reset_mid_cycle(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    exp_btn_q.delete();
    exp_tx_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef CONTROLLER_UART_CMD_EN
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (10) @(negedge clk);
    end
    rxd = 1'b1;
  endtask
`endif

  initial begin
    int n;
`ifdef CONTROLLER_UART_CMD_EN
    int f0;
`endif
    pattern = 8'h5A;
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_t0");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 0x5A read and report, then idle pad, then assorted patterns
    wait_first_poll("first_poll_delay");
    wait_ready(300);
    pattern = 8'h00;
    wait_ready(300);
    wait_ready(300);
    pattern = 8'hA5;
    wait_ready(300);
    pattern = 8'h81;
    wait_ready(300);
    pattern = 8'h3C;
    wait_ready(300);

    // Reset while the start bit of the 0x3C report is on the line
    n = 0;
    while (n < 30 && txd) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", int'(txd), 0);
    pattern = 8'hC3;
    pulse_reset_mid_cycle("rst_tx");

    // Reset during READ after three bits, then a full clean read
    wait_first_poll("poll_after_tx_reset");
    wait_sample_rises(3);
    check("sample_high_pre_rst", int'(sample), 1);
    pulse_reset_mid_cycle("rst_read");
    wait_first_poll("poll_after_read_reset");
    wait_ready(300);
    repeat (120) @(negedge clk);

`ifdef CONTROLLER_UART_CMD_EN
    period_chk = 1'b0;
    pattern = 8'h96;
    wait_ready(300);
    f0 = cyc;
    send_rx(8'h70, 1'b1);
    repeat (20) @(negedge clk);
    check("cmd_70_poll", int'(last_poll >= f0 + 90 && last_poll <= f0 + 110), 1);
    wait_ready(300);
    f0 = cyc;
    send_rx(8'h71, 1'b1);
    repeat (20) @(negedge clk);
    check("cmd_71_no_poll", int'(last_poll > f0), 0);
    wait_ready(300);
    f0 = cyc;
    send_rx(8'h70, 1'b0);
    repeat (20) @(negedge clk);
    check("cmd_badstop_no_poll", int'(last_poll > f0), 0);
    repeat (60) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
